ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_iter_core.sv | 44 ++++
 rtl/ex_muldiv.sv | 87 ++++++++
 tb/tb_ex_muldiv.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct3 encodings and FSM state encoding shared by the M-extension unit, decoder and hazard unit
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add or restoring shift-subtract step per cycle on unsigned magnitudes
module muldiv_iter_core #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n,
  output logic            last
);
  logic [XLEN-1:0] hi, lo, d;
  logic [5:0] cnt;
  logic [XLEN:0] sum;
  logic [XLEN+1:0] diff;
  logic ge;
  // hi:lo is the product accumulator or remainder:quotient; exposing next values lets the top register the result on the final step
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    diff = {1'b0, hi, lo[XLEN-1]} - {2'b0, d};
    ge = ~diff[XLEN+1];
    hi_n = is_div ? (ge ? diff[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]}) : sum[XLEN:1];
    lo_n = is_div ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
  end
  assign last = cnt == 6'(XLEN - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hi <= '0;
      lo <= '0;
      d <= '0;
      cnt <= '0;
    end else if (load) begin
      hi <= '0;
      lo <= x;
      d <= y;
      cnt <= '0;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 6'd1;
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide for the EX stage with sign fix-up and pipeline stall control
module ex_muldiv import muldiv_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t state;
  logic [2:0] op_q;
  logic neg_q, sa, sb, na, nb, div0, ovf, go, last;
  logic [XLEN-1:0] ma, mb, hi_n, lo_n, spec, fin;
  logic [2*XLEN-1:0] p;
  always_comb begin
    sa = op == OP_MULH | op == OP_MULHSU | op == OP_DIV | op == OP_REM;
    sb = op == OP_MULH | op == OP_DIV | op == OP_REM;
    na = sa & a[XLEN-1];
    nb = sb & b[XLEN-1];
    ma = na ? -a : a;
    mb = nb ? -b : b;
    div0 = op_is_div(op) & (b == '0);
    ovf = (op == OP_DIV | op == OP_REM) & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    // overflow quotient equals the dividend itself, so both corner cases pick between a, all-ones and zero
    spec = div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    go = (state == S_IDLE) & start & ~flush;
    p = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    fin = op_q == OP_MUL ? lo_n :
          !op_q[2]       ? p[2*XLEN-1:XLEN] :
          op_q[1]        ? (neg_q ? -hi_n : hi_n) :
                           (neg_q ? -lo_n : lo_n);
  end
  assign stall_req = go | (state == S_CALC);
  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk(clk),
    .rst(rst),
    .load(go & ~(div0 | ovf)),
    .step((state == S_CALC) & ~flush),
    .is_div(op_q[2]),
    .x(ma),
    .y(mb),
    .hi_n(hi_n),
    .lo_n(lo_n),
    .last(last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      op_q <= '0;
      neg_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else case (state)
      S_IDLE: if (start) begin
        op_q <= op;
        neg_q <= (op[2] & op[1]) ? na : na ^ nb;
        if (div0 | ovf) begin
          state <= S_DONE;
          done <= 1'b1;
          result <= spec;
        end else begin
          state <= S_CALC;
          busy <= 1'b1;
        end
      end
      S_CALC: if (last) begin
        state <= S_DONE;
        busy <= 1'b0;
        done <= 1'b1;
        result <= fin;
      end
      default: begin
        state <= S_IDLE;
        done <= 1'b0;
      end
    endcase
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized scoreboard bench for ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic stall_req, busy, done;
  logic [31:0] result;
  int total = 0, bad = 0, cyc = 0, stall_run = 0;
  typedef struct {
    logic [31:0] exp;
    int due;
    int stalls;
    logic [2:0] op;
  } txn_t;
  txn_t q[$];
  txn_t t;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    #2;
    if (stall_req) stall_run++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint unsigned ux = 64'(x);
    longint unsigned uy = 64'(y);
    case (o)
      3'd0: return 32'(ux * uy);
      3'd1: return 32'((sx * sy) >>> 32);
      3'd2: return 32'((sx * longint'(uy)) >>> 32);
      3'd3: return 32'((ux * uy) >> 32);
      3'd4: return (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: return (y == 0) ? x : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
    bit sp;
    sp = o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    stall_run = 0;
    if (track) q.push_back('{model(o, x, y), cyc + 1 + (sp ? 0 : 32), sp ? 1 : 33, o});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d results pending, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickv();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: result %h, expected no done pulse", result);
        end else begin
          t = q.pop_front();
          chk($sformatf("result_op%0d", t.op), result, t.exp);
          chk($sformatf("latency_op%0d", t.op), 32'(cyc), 32'(t.due));
          chk($sformatf("stall_cycles_op%0d", t.op), 32'(stall_run), 32'(t.stalls));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_stall", 32'(stall_req), 32'h0);
    // directed corner cases
    issue(3'd0, 32'd7, 32'd6, 1'b1); drain();
    issue(3'd1, 32'hFFFFFFFF, 32'd2, 1'b1); drain();
    issue(3'd3, 32'hFFFFFFFF, 32'd2, 1'b1); drain();
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); drain();
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1); drain();
    issue(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1); drain();
    issue(3'd5, 32'd5, 32'd0, 1'b1); drain();
    issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain();
    issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1); drain();
    issue(3'd7, 32'h12345678, 32'd0, 1'b1); drain();
    // flush mid-divide: no done, back to IDLE
    issue(3'd4, 32'd100, 32'd7, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_done", 32'(done), 32'h0);
    chk("flush_stall", 32'(stall_req), 32'h0);
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
    issue(3'd0, 32'd3, 32'd3, 1'b1); drain();
    // start held high during CALC must be ignored
    issue(3'd0, 32'd123, 32'd456, 1'b1);
    start = 1'b1; op = 3'd4; a = 32'd9; b = 32'd0;
    repeat (20) @(negedge clk);
    start = 1'b0;
    drain();
    // asynchronous reset mid-multiply
    issue(3'd0, 32'd5, 32'd5, 1'b0);
    repeat (13) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_stall", 32'(stall_req), 32'h0);
    chk("arst_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    issue(3'd0, 32'd2, 32'd2, 1'b1); drain();
    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(7)), pickv(), pickv(), 1'b1);
      drain();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
